// File: rtl/drive_pkg.sv
// Shared encodings for the drive-mode arbiter: motor modes, arbiter states and button decode.
package drive_pkg;

  localparam int unsigned DistW = 20;

  typedef enum logic [1:0] {
    ModeLeft   = 2'd0,
    ModeDirect = 2'd1,
    ModeRight  = 2'd2,
    ModeStop   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StTrack   = 2'd0,
    StManual  = 2'd1,
    StBlocked = 2'd2,
    StSearch  = 2'd3
  } arb_state_e;

  // Manual priority STOP > RIGHT > DIRECT > LEFT; LEFT is the fall-through.
  function automatic mode_e btn_to_mode(input logic b_stop, input logic b_right,
                                        input logic b_direct);
    if (b_stop) return ModeStop;
    if (b_right) return ModeRight;
    if (b_direct) return ModeDirect;
    return ModeLeft;
  endfunction

endpackage

// File: rtl/obstacle_filter.sv
// Hysteretic obstacle flag from ultrasonic samples; powers up asserted so nothing moves
// until enough clear readings arrive.
module obstacle_filter
  import drive_pkg::*;
#(
  parameter int unsigned STOP_CM        = 20,
  parameter int unsigned RESUME_CM      = 25,
  parameter int unsigned RESUME_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DistW-1:0] distance,
  input  logic             dist_valid,
  output logic             obstacle
);

  localparam int unsigned CntW = (RESUME_SAMPLES < 2) ? 1 : $clog2(RESUME_SAMPLES + 1);

  logic            r_obstacle;
  logic [CntW-1:0] r_clear_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_obstacle  <= 1'b1;
      r_clear_cnt <= '0;
    end else if (dist_valid) begin
      if (distance < DistW'(STOP_CM)) begin
        r_obstacle  <= 1'b1;
        r_clear_cnt <= '0;
      end else if (distance < DistW'(RESUME_CM)) begin
        // Dead band: flag untouched, but the clear streak is broken.
        r_clear_cnt <= '0;
      end else if (r_obstacle) begin
        if (r_clear_cnt >= CntW'(RESUME_SAMPLES - 1)) begin
          r_obstacle  <= 1'b0;
          r_clear_cnt <= '0;
        end else begin
          r_clear_cnt <= r_clear_cnt + 1'b1;
        end
      end
    end
  end

  assign obstacle = r_obstacle;

endmodule

// File: rtl/drive_mode_arbiter.sv
// Arbitrates motor mode between obstacle stop, manual buttons and the line tracker.
// Define DRIVE_ARB_LOST_SEARCH_EN to enable the lost-line SEARCH state.
module drive_mode_arbiter
  import drive_pkg::*;
#(
  parameter int unsigned STOP_CM        = 20,
  parameter int unsigned RESUME_CM      = 25,
  parameter int unsigned RESUME_SAMPLES = 3,
  parameter int unsigned HOLD_CYCLES    = 1_000_000,
  parameter int unsigned LOST_CYCLES    = 500_000,
  parameter int unsigned SEARCH_CYCLES  = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DistW-1:0] distance,
  input  logic             dist_valid,
  input  logic             btn_stop,
  input  logic             btn_right,
  input  logic             btn_direct,
  input  logic             btn_left,
  input  logic [1:0]       track_state,
  output logic [1:0]       mode,
  output logic             obstacle,
  output logic [1:0]       arb_state
);

`ifdef DRIVE_ARB_LOST_SEARCH_EN
  localparam bit SearchEn = 1'b1;
`else
  localparam bit SearchEn = 1'b0;
`endif

  localparam int unsigned HoldW   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned LostW   = $clog2(LOST_CYCLES + 1);
  localparam int unsigned SearchW = $clog2(SEARCH_CYCLES + 1);

  logic               w_obstacle;
  logic               w_any_btn;
  mode_e              w_btn_mode;
  mode_e              w_track;
  logic               w_track_turn;

  arb_state_e         r_state;
  mode_e              r_mode;
  mode_e              r_last_turn;
  logic [HoldW-1:0]   r_hold_cnt;
  logic [LostW-1:0]   r_lost_cnt;
  logic [SearchW-1:0] r_search_cnt;

  obstacle_filter #(
    .STOP_CM       (STOP_CM),
    .RESUME_CM     (RESUME_CM),
    .RESUME_SAMPLES(RESUME_SAMPLES)
  ) u_obstacle_filter (
    .clk       (clk),
    .rst       (rst),
    .distance  (distance),
    .dist_valid(dist_valid),
    .obstacle  (w_obstacle)
  );

  assign w_any_btn    = btn_stop | btn_right | btn_direct | btn_left;
  assign w_btn_mode   = btn_to_mode(btn_stop, btn_right, btn_direct);
  assign w_track      = mode_e'(track_state);
  assign w_track_turn = (w_track == ModeLeft) || (w_track == ModeRight);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StBlocked;
      r_mode       <= ModeStop;
      r_last_turn  <= ModeRight;
      r_hold_cnt   <= '0;
      r_lost_cnt   <= '0;
      r_search_cnt <= '0;
    end else if (w_obstacle) begin
      r_state      <= StBlocked;
      r_mode       <= ModeStop;
      r_hold_cnt   <= '0;
      r_lost_cnt   <= '0;
      r_search_cnt <= '0;
    end else if (w_any_btn) begin
      r_state      <= StManual;
      r_mode       <= w_btn_mode;
      r_hold_cnt   <= '0;
      r_lost_cnt   <= '0;
      r_search_cnt <= '0;
    end else begin
      unique case (r_state)
        StTrack, StBlocked: begin
          r_state <= StTrack;
          r_mode  <= w_track;
          if (w_track_turn) r_last_turn <= w_track;
          if (w_track == ModeStop) begin
            if (SearchEn && (r_lost_cnt >= LostW'(LOST_CYCLES - 1))) begin
              r_state      <= StSearch;
              r_mode       <= r_last_turn;
              r_lost_cnt   <= '0;
              r_search_cnt <= '0;
            end else if (r_lost_cnt != LostW'(LOST_CYCLES)) begin
              r_lost_cnt <= r_lost_cnt + 1'b1;
            end
          end else begin
            r_lost_cnt <= '0;
          end
        end
        StManual: begin
          if (r_hold_cnt >= HoldW'(HOLD_CYCLES)) begin
            r_state    <= StTrack;
            r_mode     <= w_track;
            r_hold_cnt <= '0;
            r_lost_cnt <= '0;
            if (w_track_turn) r_last_turn <= w_track;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        StSearch: begin
          if (w_track != ModeStop) begin
            r_state      <= StTrack;
            r_mode       <= w_track;
            r_lost_cnt   <= '0;
            r_search_cnt <= '0;
            if (w_track_turn) r_last_turn <= w_track;
          end else if (r_search_cnt >= SearchW'(SEARCH_CYCLES - 1)) begin
            // Timed out: park until the tracker sees the line again.
            r_mode       <= ModeStop;
            r_search_cnt <= SearchW'(SEARCH_CYCLES);
          end else begin
            r_mode       <= r_last_turn;
            r_search_cnt <= r_search_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign mode      = r_mode;
  assign obstacle  = w_obstacle;
  assign arb_state = r_state;

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Directed scoreboard bench for drive_mode_arbiter; follows DRIVE_ARB_LOST_SEARCH_EN if defined.
module tb_drive_mode_arbiter;

  localparam logic [1:0] ML = 2'd0, MD = 2'd1, MR = 2'd2, MS = 2'd3;
  localparam logic [1:0] TRK = 2'd0, MAN = 2'd1, BLK = 2'd2, SRC = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] distance = '0;
  logic        dist_valid = 1'b0;
  logic        btn_stop = 1'b0, btn_right = 1'b0, btn_direct = 1'b0, btn_left = 1'b0;
  logic [1:0]  track_state = MD;
  logic [1:0]  mode;
  logic        obstacle;
  logic [1:0]  arb_state;

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic       obs;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  drive_mode_arbiter #(
    .STOP_CM       (20),
    .RESUME_CM     (25),
    .RESUME_SAMPLES(3),
    .HOLD_CYCLES   (8),
    .LOST_CYCLES   (4),
    .SEARCH_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .distance   (distance),
    .dist_valid (dist_valid),
    .btn_stop   (btn_stop),
    .btn_right  (btn_right),
    .btn_direct (btn_direct),
    .btn_left   (btn_left),
    .track_state(track_state),
    .mode       (mode),
    .obstacle   (obstacle),
    .arb_state  (arb_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [1:0] m, input logic o, input logic [1:0] s);
    exp_t e;
    e.tag = tag; e.mode = m; e.obs = o; e.st = s;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 required=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (mode === e.mode) else begin
      errors++;
      $error("FAIL %s mode observed=%0d required=%0d", e.tag, mode, e.mode);
    end
    checks++;
    assert (obstacle === e.obs) else begin
      errors++;
      $error("FAIL %s obstacle observed=%0d required=%0d", e.tag, obstacle, e.obs);
    end
    checks++;
    assert (arb_state === e.st) else begin
      errors++;
      $error("FAIL %s arb_state observed=%0d required=%0d", e.tag, arb_state, e.st);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] m, input logic o, input logic [1:0] s);
    push(tag, m, o, s);
    tick();
    check();
  endtask

  task automatic pulse(input logic [19:0] d, input string tag, input logic [1:0] m, input logic o,
                       input logic [1:0] s);
    push(tag, m, o, s);
    distance   = d;
    dist_valid = 1'b1;
    tick();
    dist_valid = 1'b0;
    check();
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #2;
    push(tag, MS, 1'b1, BLK);
    check();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    push("reset", MS, 1'b1, BLK);
    check();
    rst = 1'b0;

    // Power-up release needs three clear readings.
    pulse(20'd40, "clr1", MS, 1'b1, BLK);
    pulse(20'd40, "clr2", MS, 1'b1, BLK);
    pulse(20'd40, "clr3", MS, 1'b0, BLK);
    step("track_direct", MD, 1'b0, TRK);

    pulse(20'd15, "obs_set", MD, 1'b1, TRK);
    step("obs_stop", MS, 1'b1, BLK);
    pulse(20'd22, "band22a", MS, 1'b1, BLK);
    pulse(20'd40, "hyst40a", MS, 1'b1, BLK);
    pulse(20'd40, "hyst40b", MS, 1'b1, BLK);
    pulse(20'd22, "band22b", MS, 1'b1, BLK);
    pulse(20'd40, "rel40a", MS, 1'b1, BLK);
    pulse(20'd40, "rel40b", MS, 1'b1, BLK);
    pulse(20'd40, "rel40c", MS, 1'b0, BLK);
    step("resume", MD, 1'b0, TRK);
    pulse(20'd20, "edge20", MD, 1'b0, TRK);
    step("edge20_hold", MD, 1'b0, TRK);

    btn_right = 1'b1;
    btn_left  = 1'b1;
    for (int i = 0; i < 5; i++) step("man_press", MR, 1'b0, MAN);
    btn_right = 1'b0;
    btn_left  = 1'b0;
    for (int i = 0; i < 8; i++) step("man_hold", MR, 1'b0, MAN);
    step("man_exit", MD, 1'b0, TRK);

    btn_direct = 1'b1;
    step("man_direct", MD, 1'b0, MAN);
    pulse(20'd10, "blk_obs", MD, 1'b1, MAN);
    step("blk_btn", MS, 1'b1, BLK);
    step("blk_stay", MS, 1'b1, BLK);
    btn_direct  = 1'b0;
    track_state = ML;
    pulse(20'd40, "blk_c1", MS, 1'b1, BLK);
    pulse(20'd40, "blk_c2", MS, 1'b1, BLK);
    pulse(20'd40, "blk_c3", MS, 1'b0, BLK);
    step("track_left", ML, 1'b0, TRK);
    step("track_left2", ML, 1'b0, TRK);

    track_state = MS;
`ifdef DRIVE_ARB_LOST_SEARCH_EN
    for (int i = 0; i < 3; i++) step("lost", MS, 1'b0, TRK);
    step("search_enter", ML, 1'b0, SRC);
    for (int i = 0; i < 15; i++) step("search_turn", ML, 1'b0, SRC);
    for (int i = 0; i < 3; i++) step("search_timeout", MS, 1'b0, SRC);
`else
    for (int i = 0; i < 22; i++) step("lost_stop", MS, 1'b0, TRK);
`endif
    track_state = MD;
    step("refind", MD, 1'b0, TRK);

`ifdef DRIVE_ARB_LOST_SEARCH_EN
    track_state = MS;
    for (int i = 0; i < 3; i++) step("lost2", MS, 1'b0, TRK);
    step("search2_enter", ML, 1'b0, SRC);
    step("search2_turn", ML, 1'b0, SRC);
    async_reset("rst_search");
    track_state = MD;
    pulse(20'd40, "rs_c1", MS, 1'b1, BLK);
    pulse(20'd40, "rs_c2", MS, 1'b1, BLK);
    pulse(20'd40, "rs_c3", MS, 1'b0, BLK);
    step("rs_track", MD, 1'b0, TRK);
    // last_turn returns to RIGHT after reset.
    track_state = MS;
    for (int i = 0; i < 3; i++) step("lost3", MS, 1'b0, TRK);
    step("search_right", MR, 1'b0, SRC);
    track_state = MD;
    step("refind2", MD, 1'b0, TRK);
`endif

    btn_stop = 1'b1;
    step("man_stop", MS, 1'b0, MAN);
    btn_stop = 1'b0;
    for (int i = 0; i < 3; i++) step("hold_stop", MS, 1'b0, MAN);
    async_reset("rst_hold");

    track_state = MD;
    pulse(20'd40, "pr1", MS, 1'b1, BLK);
    pulse(20'd40, "pr2", MS, 1'b1, BLK);
    pulse(20'd25, "pr3_edge25", MS, 1'b0, BLK);
    step("pr_go", MD, 1'b0, TRK);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_left observed=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_mode_arbiter.md
DRIVE_MODE_ARBITER -- requirements
Module: drive_mode_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock, clk; reset rst, asynchronous, active-high.
REQ-002 Parameter STOP_CM, 20, obstacle-assert threshold in cm (distance < STOP_CM).
REQ-003 Parameter RESUME_CM, 25, obstacle-release threshold in cm (distance >= RESUME_CM).
REQ-004 Parameter RESUME_SAMPLES, 3, consecutive clear samples required to release obstacle.
REQ-005 Parameter HOLD_CYCLES, 1_000_000, manual-mode hold after all buttons released.
REQ-006 Parameter LOST_CYCLES, 500_000, cycles of track_state==STOP before search starts.
REQ-007 Parameter SEARCH_CYCLES, 50_000_000, search timeout.
REQ-008 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- distance  in  20  ultrasonic range, cm
- dist_valid  in  1  one-cycle pulse, distance updated
- btn_stop, btn_right, btn_direct, btn_left  in  1 each  synchronised, debounced levels
- track_state  in  2  line-tracker mode request
- mode  out  2  registered motor mode
- obstacle  out  1  filtered obstacle flag
- arb_state  out  2  current FSM state, debug

Function
REQ-009 Mode encoding SHALL be LEFT=0, DIRECT=1, RIGHT=2, STOP=3, for track_state and mode.
REQ-010 obstacle SHALL set on the cycle after a dist_valid with distance < STOP_CM.
REQ-011 obstacle SHALL clear only after RESUME_SAMPLES consecutive dist_valid samples with distance >= RESUME_CM; any sample < RESUME_CM resets the count; STOP_CM <= distance < RESUME_CM leaves obstacle unchanged.
REQ-012 distance SHALL be ignored on cycles where dist_valid is 0.
REQ-013 FSM states SHALL be TRACK, MANUAL, BLOCKED, SEARCH.
REQ-014 Any state SHALL go to BLOCKED when obstacle is 1; BLOCKED drives mode=STOP and exits to TRACK when obstacle clears.
REQ-015 TRACK SHALL go to MANUAL when any button is high; MANUAL mode priority is STOP > RIGHT > DIRECT > LEFT.
REQ-016 In MANUAL with all buttons released, mode SHALL hold the last manual value for HOLD_CYCLES, then return to TRACK; a new press restarts the hold counter.
REQ-017 TRACK SHALL drive mode = track_state and record the last non-STOP LEFT/RIGHT value as last_turn (reset value RIGHT).
REQ-018 Priority when events coincide SHALL be obstacle > buttons > tracker/search.
REQ-019 mode SHALL be registered: one clk latency from the deciding input to mode.
REQ-020 Counters SHALL saturate at their terminal count, never wrap.
REQ-021 Entering BLOCKED SHALL clear the hold, lost and search counters.

Reset
REQ-022 While rst is high, mode=STOP, obstacle=1, arb_state=BLOCKED, all counters 0, last_turn=RIGHT.
REQ-023 After rst release, obstacle SHALL clear only via REQ-011, so the car does not move before RESUME_SAMPLES clear readings.
REQ-024 rst asserted mid-search or mid-hold SHALL abort immediately to the REQ-022 values.

Configuration
REQ-025 Macro DRIVE_ARB_LOST_SEARCH_EN SHALL control the SEARCH feature.
REQ-026 With the macro defined: TRACK with track_state==STOP for LOST_CYCLES consecutive cycles enters SEARCH.
REQ-027 SEARCH SHALL drive mode=last_turn.
REQ-028 SEARCH SHALL return to TRACK when track_state != STOP.
REQ-029 On SEARCH_CYCLES timeout, SEARCH SHALL drive mode=STOP and remain there until track_state != STOP.
REQ-030 Without the macro, SEARCH is unreachable and TRACK passes track_state==STOP through as mode=STOP.

Structure
REQ-031 Package drive_pkg SHALL hold the mode encodings, the FSM state typedef and the arb_state encoding (TRACK=0, MANUAL=1, BLOCKED=2, SEARCH=3).
REQ-032 Sub-module obstacle_filter SHALL implement REQ-010/011/012 (inputs: distance, dist_valid; output: obstacle).

Verification (bench params: HOLD_CYCLES=8, LOST_CYCLES=4, SEARCH_CYCLES=16, RESUME_SAMPLES=3)
REQ-033 Release rst, send 3 dist_valid pulses with distance=40 -> obstacle falls after the 3rd pulse; mode follows track_state=DIRECT (1) one cycle later.
REQ-034 In TRACK, send distance=15 -> mode=STOP next cycle. Then send 22,40,40,22 -> obstacle stays 1. Then send 40,40,40 -> obstacle releases.
REQ-035 Press btn_right and btn_left together for 5 cycles, then release -> mode=RIGHT (2) throughout and for 8 cycles after release, then track_state value.
REQ-036 btn_direct held while distance=10 arrives -> mode=STOP, arb_state=BLOCKED.
REQ-037 Macro on: track LEFT, then track_state=STOP for 4 cycles -> SEARCH with mode=LEFT; after 16 cycles -> mode=STOP; then track_state=DIRECT -> TRACK, mode=DIRECT.
REQ-038 Macro off: same stimulus as REQ-037 -> mode=STOP, arb_state=TRACK throughout the lost period.
